// File: rtl/zxvid_vram_port.sv
// Video RAM port: gives the fetcher fixed pixel/attribute slots, and lets a CPU
// request/ack port with Z80 WAIT use the remaining 14 phases of each 16-pixel group.
//
// state | meaning
// IDLE  | no CPU access in flight; a cpu_req is latched here
// PEND  | access latched; it executes in the first CPU slot
// ACK   | one-cycle cpu_ack; cpu_req is ignored
module zxvid_vram_port #(
  parameter int          ADDR_W     = 13,
  parameter int          VRAM_SIZE  = 6912,
  parameter logic [3:0]  PIX_PHASE  = 4'd1,
  parameter logic [3:0]  ATTR_PHASE = 4'd3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        video_phase,
  input  logic [ADDR_W-1:0] video_addr,
  output logic [7:0]        video_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic [7:0]        ram_d,
  output logic              ram_we
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_we;
  logic [7:0]        r_req_wdata;
  logic [7:0]        r_cpu_rdata;
  logic [7:0]        r_attr_hold;
  logic              w_video_slot;
  logic              w_exec;
  logic              w_in_range;

  assign w_video_slot = (video_phase == PIX_PHASE) || (video_phase == ATTR_PHASE);
  assign w_exec       = (r_state == S_PEND) && !w_video_slot;
  // Widen before comparing so the limit itself is never truncated to ADDR_W bits.
  assign w_in_range   = (32'(r_req_addr) < 32'(VRAM_SIZE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req) w_state_nxt = S_PEND;
      S_PEND:  if (!w_video_slot) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr = video_addr;
    ram_d    = 8'h00;
    ram_we   = 1'b0;
    cpu_ack  = (r_state == S_ACK);
    if (w_exec && w_in_range) begin
      ram_addr = r_req_addr;
      if (r_req_we) begin
        ram_d  = r_req_wdata;
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_attr_hold <= 8'h00;
    end else begin
      if (r_state == S_IDLE && cpu_req) begin
        r_req_addr  <= cpu_addr;
        r_req_we    <= cpu_we;
        r_req_wdata <= cpu_wdata;
      end
      if (w_exec && !r_req_we) r_cpu_rdata <= w_in_range ? ram_q : 8'hFF;
      // Attribute byte must survive until the fetcher samples it in phase 15.
      if (video_phase == ATTR_PHASE) r_attr_hold <= ram_q;
    end
  end

  assign video_data = (video_phase == PIX_PHASE) ? ram_q : r_attr_hold;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_wait   = cpu_req & ~cpu_ack;

endmodule

// File: doc/zxvid_vram_port.md
Name: zxvid_vram_port

Overview:
- Memory-side responder for the Spectrum-layout video fetcher.
- Owns the single 8 KB asynchronous-read video RAM. Serves the fetcher's two fixed reads per 16-pixel group: pixel byte and attribute byte.
- Gives every other slot in the group to a CPU request/acknowledge port with Z80 WAIT generation.
- Sits between the video fetcher, the CPU bus decoder and the video RAM instance.

Parameters:
- ADDR_W, 13, video RAM address width.
- VRAM_SIZE, 6912, number of valid bytes; CPU addresses at or above this are out of range.
- PIX_PHASE, 1, phase in which the pixel-byte address from the fetcher is valid.
- ATTR_PHASE, 3, phase in which the attribute-byte address from the fetcher is valid.

Ports:
- clk  in  1  25 MHz pixel clock
- reset_n  in  1  asynchronous reset, active low
- video_phase  in  4  fetcher horizontal position x[3:0] for the current cycle
- video_addr  in  13  fetcher read address (registered by the fetcher)
- video_data  out  8  fetcher read data
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  13  CPU byte address within video RAM
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  Z80 WAIT, high while a request is outstanding
- ram_addr  out  13  video RAM address
- ram_q  in  8  video RAM read data, combinational from ram_addr in the same cycle
- ram_d  out  8  video RAM write data
- ram_we  out  1  video RAM write enable, written on rising clk

Behaviour:
- Slots:
  - Video slot: video_phase == PIX_PHASE or == ATTR_PHASE.
  - CPU slot: all other 14 phases.
  - In a video slot: ram_addr = video_addr, ram_we = 0, regardless of CPU state.
- Video read path:
  - When video_phase == PIX_PHASE: video_data = ram_q, combinational passthrough.
  - Otherwise: video_data = attr_hold.
  - attr_hold is registered from ram_q on the clk edge ending the ATTR_PHASE cycle. It stays stable through phase 15, where the fetcher samples it.
  - No video read is ever delayed or dropped.
- CPU FSM, states IDLE, PEND, ACK:
  - IDLE: if cpu_req=1, latch cpu_addr, cpu_we, cpu_wdata into req registers and go to PEND. Otherwise stay.
  - PEND:
    - If the current cycle is a CPU slot, execute from the latched registers and go to ACK. Otherwise stay in PEND.
    - Write, in range: ram_addr = latched address, ram_d = latched data, ram_we = 1.
    - Read, in range: ram_addr = latched address; register ram_q into cpu_rdata at the end of the cycle.
    - Out of range (address >= VRAM_SIZE): no RAM cycle, ram_we = 0. Reads return cpu_rdata = 8'hFF; writes are discarded. Still proceeds to ACK.
  - ACK: cpu_ack = 1 for exactly this cycle, then go to IDLE. cpu_req is ignored in ACK.
  - A requester still asserting cpu_req in the cycle after ACK starts a new access.
- Latency, request seen in IDLE to cpu_ack high:
  - Minimum 2 cycles.
  - Maximum 3 cycles (PEND lands on one video slot; video slots are never adjacent).
- cpu_wait = cpu_req & ~cpu_ack, combinational.
- When no CPU access is executing in a CPU slot: ram_addr = video_addr, ram_we = 0, ram_d = 0.
- Reset (asynchronous, any cycle, including mid-PEND):
  - FSM to IDLE; the pending access is abandoned with no write and no ack.
  - cpu_ack = 0, cpu_rdata = 8'h00, attr_hold = 8'h00, ram_we = 0.
  - Req registers cleared.
- Widths: in-range compare is unsigned 13-bit against VRAM_SIZE. No wrap-around; 8191 is out of range.

Test Plan:
- CPU write 8'hA5 to address 13'h0000, request raised in phase 5 → ram_we=1 for exactly one cycle in phase 6; cpu_ack high in phase 7; RAM[0]=8'hA5.
- CPU read of 13'h1800 (preloaded 8'h47), request raised in phase 0 → PEND falls in phase 1 (video slot) and stalls; executes in phase 2; cpu_ack in phase 3 with cpu_rdata=8'h47. Fetcher pixel read in phase 1 is unaffected.
- Fetcher with pixel address 13'h0000 = 8'hFF and attribute address 13'h1800 = 8'h38 → video_data=8'hFF in phase 1; video_data=8'h38 from phase 4 through phase 15, including while the CPU writes 13'h1800 in phase 5.
- Out-of-range write to 13'h1B00, then read of 13'h1FFF → ram_we stays 0; read acks with cpu_rdata=8'hFF.
- Back-to-back: cpu_req held high across ACK → exactly two acks, separated by at least 2 cycles; cpu_wait low only during ack cycles.
- reset_n pulsed low while in PEND with a write pending → no RAM write, no cpu_ack; all outputs at reset values immediately, without a clock edge.
